// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: instruction memory port, redirect/halt controls
// and the valid/ready handshake towards decode.
// master = fetch unit side, slave = memory/decode side.
interface fetch_if #(
    parameter int N = 16
);
    logic [N-1:0] imem_addr;
    logic         imem_rd;
    logic [N-1:0] imem_data;
    logic         redirect_en;
    logic [N-1:0] redirect_addr;
    logic         halt_in;
    logic         ready_in;
    logic         valid_out;
    logic [N-1:0] instr_out;
    logic [N-1:0] pc_out;
    logic [N-1:0] pc_inc_out;
    logic         halted;

    modport master (
        output imem_addr, imem_rd, valid_out, instr_out, pc_out, pc_inc_out, halted,
        input  imem_data, redirect_en, redirect_addr, halt_in, ready_in
    );

    modport slave (
        input  imem_addr, imem_rd, valid_out, instr_out, pc_out, pc_inc_out, halted,
        output imem_data, redirect_en, redirect_addr, halt_in, ready_in
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads a combinational instruction
// memory, queues {instr, pc, pc+INC} in a DEPTH-entry prefetch FIFO and
// hands the head to decode over valid/ready. Supports redirect (flush +
// new PC), downstream back-pressure and a sticky halt that only rst clears.
// Optional macro FETCH_PERF_CNT_EN adds saturating fetch/stall/flush counters.
module fetch_unit #(
    parameter int          N        = 16,
    parameter int          INC      = 2,
    parameter int          DEPTH    = 2,
    parameter int unsigned RESET_PC = 0
) (
    input  logic      clk,
    input  logic      rst,
    fetch_if.master   bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [N-1:0] o_fetch_cnt,
    output logic [N-1:0] o_stall_cnt,
    output logic [N-1:0] o_flush_cnt
`endif
);
    localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int            CW   = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic {S_RUN = 1'b0, S_HALTED = 1'b1} state_t;

    state_t        r_state, w_state_nxt;
    logic [N-1:0]  r_pc;
    logic [PW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [N-1:0]  r_buf_instr  [DEPTH];
    logic [N-1:0]  r_buf_pc     [DEPTH];
    logic [N-1:0]  r_buf_pc_inc [DEPTH];

    logic          w_run, w_redirect, w_valid, w_pop, w_push;
    logic [N-1:0]  w_pc_inc;

    // Next state plus handshake decode; redirect is only honoured in RUN,
    // and rst masks push/valid so nothing moves in a reset cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_run       = (r_state == S_RUN);
        w_redirect  = !rst && w_run && bus.redirect_en;
        w_valid     = !rst && (r_count != '0) && !w_redirect;
        w_pop       = w_valid && bus.ready_in;
        w_push      = !rst && w_run && !bus.redirect_en && ((r_count < FULL) || w_pop);
        w_pc_inc    = r_pc + N'(INC);
        if (w_run && bus.halt_in && !bus.redirect_en)
            w_state_nxt = S_HALTED;
    end

    assign bus.imem_addr  = r_pc;
    assign bus.imem_rd    = w_push;
    assign bus.valid_out  = w_valid;
    assign bus.instr_out  = r_buf_instr[r_rd_ptr];
    assign bus.pc_out     = r_buf_pc[r_rd_ptr];
    assign bus.pc_inc_out = r_buf_pc_inc[r_rd_ptr];
    assign bus.halted     = (r_state == S_HALTED);

    // State register; HALTED is sticky until reset.
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_RUN;
        else
            r_state <= w_state_nxt;
    end

    // PC, FIFO pointers/occupancy and buffer writes; redirect flushes the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc     <= N'(RESET_PC);
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_buf_instr[k]  <= '0;
                r_buf_pc[k]     <= '0;
                r_buf_pc_inc[k] <= '0;
            end
        end else if (w_redirect) begin
            r_pc     <= bus.redirect_addr;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_buf_instr[r_wr_ptr]  <= bus.imem_data;
                r_buf_pc[r_wr_ptr]     <= r_pc;
                r_buf_pc_inc[r_wr_ptr] <= w_pc_inc;
                r_wr_ptr               <= r_wr_ptr + PW'(1);
                r_pc                   <= w_pc_inc;
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [N-1:0] r_fetch_cnt, r_stall_cnt, r_flush_cnt;

    // Saturating event counters: pushes, full-without-pop cycles, redirects.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_cnt <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_push && (r_fetch_cnt != '1))
                r_fetch_cnt <= r_fetch_cnt + N'(1);
            if ((r_count == FULL) && !w_pop && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + N'(1);
            if (w_redirect && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + N'(1);
        end
    end

    assign o_fetch_cnt = r_fetch_cnt;
    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;
`endif
endmodule
